regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Sequences and shares the 32x32 register file between the pipeline and a debug/host port.
- After reset it sweeps the file to known values: r29 = stack top, all others 0. It stalls the pipeline during the sweep.
- Arbitrates the single write port: WB always wins; debug writes go in idle WB cycles.
- Lends read port 1 to debug reads, and provides write-to-read bypass for the ID stage.

Parameters:
- NUM_REGS, 32, register count; sweep length.
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.
- SP_INDEX, 29, register loaded with SP_INIT during the sweep.
- SP_INIT, 252, stack pointer init value (byte address, top of data memory).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- wb_we  in  1  WB stage register write enable.
- wb_addr  in  ADDR_W  WB destination register.
- wb_data  in  DATA_W  WB write data.
- id_rs, id_rt  in  ADDR_W  ID stage source register addresses.
- id_data1, id_data2  out  DATA_W  ID read data, after bypass.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  1 = debug write, 0 = debug read; stable while dbg_req is high.
- dbg_addr  in  ADDR_W  debug register address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  debug read result; registered, valid from dbg_ack onward.
- stall  out  1  freezes IF/ID (sweep or debug read).
- rf_we  out  1  register file RegWrite.
- rf_waddr  out  ADDR_W  register file WriteReg.
- rf_wdata  out  DATA_W  register file WriteData.
- rf_raddr1, rf_raddr2  out  ADDR_W  register file ReadReg1/ReadReg2.
- rf_rdata1, rf_rdata2  in  DATA_W  register file ReadData1/ReadData2.

Behaviour:
- Interface fixed: reset reset, asynchronous, active-high; clock Clk.
- State machine states: INIT, RUN, DBG_RD, DBG_ACK.
- On reset: state = INIT, sweep count cnt = 0, dbg_ack = 0, dbg_rdata = 0.
- Reset mid-operation (any state): aborts the sweep or debug transaction with no ack; the sweep restarts from cnt = 0.
- INIT:
  - stall = 1 and rf_we = 1 every cycle; rf_waddr = cnt.
  - rf_wdata = SP_INIT when cnt == SP_INDEX, else 0.
  - wb_we and dbg_req are ignored.
  - After the cnt = NUM_REGS-1 write, go to RUN; the sweep takes exactly NUM_REGS cycles.
- RUN, write port:
  - If wb_we=1 and wb_addr!=0: rf_we=1, rf_waddr=wb_addr, rf_wdata=wb_data.
  - If wb_we=1 and wb_addr==0: the write is dropped; rf_we=0.
  - If wb_we=0 and dbg_req=1 and dbg_we=1: drive the debug write (dropped if dbg_addr==0), then go to DBG_ACK.
  - A debug write waits while wb_we=1; there is no starvation bound.
- RUN, debug read: if dbg_req=1 and dbg_we=0, go to DBG_RD. This does not depend on wb_we.
- DBG_RD, one cycle:
  - stall = 1; rf_raddr1 = dbg_addr.
  - WB writes still proceed.
  - At the clock edge, dbg_rdata <= bypassed port-1 value; then go to DBG_ACK.
- DBG_ACK, one cycle: dbg_ack = 1, stall = 0, WB writes allowed; then return to RUN. The requester drops dbg_req in this cycle.
- Read addresses outside DBG_RD: rf_raddr1 = id_rs, rf_raddr2 = id_rt.
- Bypass (combinational):
  - If rf_we=1 and rf_waddr == the read address and rf_waddr != 0, the read data = rf_wdata; otherwise it is rf_rdata.
  - Address 0 always reads 0.
- stall = 1 in INIT and DBG_RD, else 0.
- Simultaneous events:
  - A WB write during the INIT sweep is lost; the pipeline is stalled, so none occur legally.
  - A debug write issued in the same cycle as WB is deferred.
  - A debug read of the register WB writes in DBG_RD returns wb_data.

Test Plan:
- Reset, run 32 cycles: stall=1 for exactly 32 cycles; rf_we writes addresses 0..31 in order; addr 29 gets 252, all others 0; then stall=0.
- RUN, wb_we=1, wb_addr=8, wb_data=0x1234, id_rs=8 in the same cycle: id_data1 = 0x1234 that cycle; the next cycle rf_rdata path returns 0x1234.
- wb_we=1, wb_addr=0, wb_data=0xFFFF: rf_we=0; id_rs=0 reads 0.
- dbg write addr=9, data=0xABCD with wb_we=1 for 3 cycles: no debug write for 3 cycles; write lands on the 4th; dbg_ack pulses on the 5th.
- dbg read addr=29 after the sweep: stall=1 for one cycle; dbg_ack next cycle; dbg_rdata=252.
- dbg read addr=10 while WB writes r10=0x55 in DBG_RD: dbg_rdata=0x55.
- Assert reset at sweep cnt=12: state=INIT, cnt=0; the full 32-cycle sweep repeats; no dbg_ack is issued for a pending request until the sweep completes.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: post-reset sweep (r29 = stack top, others 0),
// WB/debug write-port arbitration, debug read via port 1, and ID-stage write bypass.
module regfile_access_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int SP_INDEX = 29,
   parameter int SP_INIT  = 252
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   output logic [DATA_W-1:0] id_data1,
   output logic [DATA_W-1:0] id_data2,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [ADDR_W-1:0] rf_raddr1,
   output logic [ADDR_W-1:0] rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2
);

   typedef enum logic [1:0] {INIT, RUN, DBG_RD, DBG_ACK} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_INDEX);
   localparam logic [DATA_W-1:0] SP_VALUE  = DATA_W'(SP_INIT);

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_dbgRdata;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_wbWrite;

   assign w_wbWrite = wb_we && (wb_addr != '0);

   // State, sweep counter and captured debug read data
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_state    <= INIT;
         r_cnt      <= '0;
         r_dbgRdata <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == INIT)
            r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + ADDR_W'(1);
         if (r_state == DBG_RD)
            r_dbgRdata <= w_rd1;
      end
   end

   // Next state and write-port mux; WB always has priority over debug writes
   always_comb begin
      w_nextState = r_state;
      rf_we       = 1'b0;
      rf_waddr    = wb_addr;
      rf_wdata    = wb_data;
      case (r_state)
         INIT: begin
            rf_we    = 1'b1;
            rf_waddr = r_cnt;
            rf_wdata = (r_cnt == SP_ADDR) ? SP_VALUE : '0;
            if (r_cnt == LAST_ADDR)
               w_nextState = RUN;
         end
         RUN: begin
            if (wb_we) begin
               rf_we = w_wbWrite;
            end else if (dbg_req && dbg_we) begin
               rf_we       = (dbg_addr != '0);
               rf_waddr    = dbg_addr;
               rf_wdata    = dbg_wdata;
               w_nextState = DBG_ACK;
            end
            if (dbg_req && !dbg_we)
               w_nextState = DBG_RD;
         end
         DBG_RD: begin
            rf_we       = w_wbWrite;
            w_nextState = DBG_ACK;
         end
         DBG_ACK: begin
            rf_we       = w_wbWrite;
            w_nextState = RUN;
         end
         default: w_nextState = INIT;
      endcase
   end

   assign stall     = (r_state == INIT) || (r_state == DBG_RD);
   assign dbg_ack   = (r_state == DBG_ACK);
   assign dbg_rdata = r_dbgRdata;
   assign rf_raddr1 = (r_state == DBG_RD) ? dbg_addr : id_rs;
   assign rf_raddr2 = id_rt;

   // Bypass the in-flight write; r0 is hardwired to zero
   assign w_rd1 = (rf_raddr1 == '0) ? '0 :
                  (rf_we && (rf_waddr == rf_raddr1)) ? rf_wdata : rf_rdata1;
   assign w_rd2 = (rf_raddr2 == '0) ? '0 :
                  (rf_we && (rf_waddr == rf_raddr2)) ? rf_wdata : rf_rdata2;

   assign id_data1 = w_rd1;
   assign id_data2 = w_rd2;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: sweep, bypass vectors, debug
// sequences, mid-sweep reset and randomized WB traffic against a register model.
module tb_regfile_access_ctrl;

   logic        Clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  id_rs, id_rt;
   logic [31:0] id_data1, id_data2;
   logic        dbg_req, dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        stall, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;

   logic        scribble;
   logic [31:0] rfMem [32];
   logic [31:0] model [32];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        expWe;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;
   vec_t vecs [7];

   always #5 Clk = ~Clk;

   regfile_access_ctrl dut (
      .Clk(Clk), .reset(reset),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .id_rs(id_rs), .id_rt(id_rt), .id_data1(id_data1), .id_data2(id_data2),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .stall(stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
   );

   // External register file; scribble fills it with junk so the sweep is visible
   always @(posedge Clk) begin
      if (scribble) begin
         for (int i = 0; i < 32; i++) rfMem[i] <= 32'hDEAD0000 | 32'(i);
      end else if (rf_we) begin
         rfMem[rf_waddr] <= rf_wdata;
      end
   end
   assign rf_rdata1 = rfMem[rf_raddr1];
   assign rf_rdata2 = rfMem[rf_raddr2];

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] rs, input logic [4:0] rt);
      wb_we   = we;
      wb_addr = wa;
      wb_data = wd;
      id_rs   = rs;
      id_rt   = rt;
      #1;
   endtask

   // Register-file semantics: committed WB write lands at the edge
   task automatic tick();
      if (wb_we && wb_addr != 5'd0) model[wb_addr] = wb_data;
      @(negedge Clk);
   endtask

   function automatic logic [31:0] predict(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return model[a];
   endfunction

   // Sweep cycles with a bogus WB write that must be ignored
   task automatic sweepCheck(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 5'd7, 32'hBAD0BAD0, 5'd7, 5'd7);
         checkOutput($sformatf("sweep_stall[%0d]", i), stall, 1);
         checkOutput($sformatf("sweep_we[%0d]", i), rf_we, 1);
         checkOutput($sformatf("sweep_waddr[%0d]", i), rf_waddr, i);
         checkOutput($sformatf("sweep_wdata[%0d]", i), rf_wdata, (i == 29) ? 252 : 0);
         checkOutput($sformatf("sweep_ack[%0d]", i), dbg_ack, 0);
         @(negedge Clk);
      end
      wb_we = 1'b0;
   endtask

   task automatic readAll(input string tag);
      for (int i = 0; i < 32; i += 2) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(i + 1));
         checkOutput($sformatf("%s_r%0d", tag, i), id_data1, (i == 0) ? 32'd0 : model[i]);
         checkOutput($sformatf("%s_r%0d", tag, i + 1), id_data2, model[i + 1]);
         tick();
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[29] = 32'd252;
   endtask

   initial begin
      logic        rWe;
      logic [4:0]  rWa, rRs, rRt;
      logic [31:0] rWd;
      bit          gotAck;

      vecs[0] = '{1'b1, 5'd8,  32'h1234, 5'd8,  5'd29, 1'b1, 32'h1234, 32'd252};
      vecs[1] = '{1'b0, 5'd0,  32'h0,    5'd8,  5'd0,  1'b0, 32'h1234, 32'd0};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFF, 5'd0,  5'd8,  1'b0, 32'd0,    32'h1234};
      vecs[3] = '{1'b1, 5'd5,  32'h77,   5'd5,  5'd3,  1'b1, 32'h77,   32'd0};
      vecs[4] = '{1'b0, 5'd0,  32'h0,    5'd5,  5'd29, 1'b0, 32'h77,   32'd252};
      vecs[5] = '{1'b1, 5'd3,  32'hA5,   5'd8,  5'd3,  1'b1, 32'h1234, 32'hA5};
      vecs[6] = '{1'b1, 5'd0,  32'h1,    5'd0,  5'd0,  1'b0, 32'd0,    32'd0};

      reset = 1'b1; scribble = 1'b1;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; id_rs = '0; id_rt = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      @(negedge Clk);
      scribble = 1'b0;
      #1;
      checkOutput("reset_stall", stall, 1);
      checkOutput("reset_ack", dbg_ack, 0);
      checkOutput("reset_rdata", dbg_rdata, 0);
      checkOutput("reset_waddr", rf_waddr, 0);
      @(negedge Clk);
      reset = 1'b0;

      sweepCheck(32);
      resetModel();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("post_sweep_stall", stall, 0);
      readAll("sweep");

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].rs, vecs[v].rt);
         checkOutput($sformatf("vec%0d_we", v), rf_we, vecs[v].expWe);
         checkOutput($sformatf("vec%0d_id1", v), id_data1, vecs[v].exp1);
         checkOutput($sformatf("vec%0d_id2", v), id_data2, vecs[v].exp2);
         if (vecs[v].expWe) begin
            checkOutput($sformatf("vec%0d_waddr", v), rf_waddr, vecs[v].wa);
            checkOutput($sformatf("vec%0d_wdata", v), rf_wdata, vecs[v].wd);
         end
         tick();
      end

      // Debug write deferred by three WB cycles
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hABCD;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 5'd4, 32'h100 + 32'(k), 5'd0, 5'd0);
         checkOutput($sformatf("dw_defer_waddr[%0d]", k), rf_waddr, 4);
         checkOutput($sformatf("dw_defer_wdata[%0d]", k), rf_wdata, 32'h100 + 32'(k));
         checkOutput($sformatf("dw_defer_ack[%0d]", k), dbg_ack, 0);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("dw_land_we", rf_we, 1);
      checkOutput("dw_land_waddr", rf_waddr, 9);
      checkOutput("dw_land_wdata", rf_wdata, 32'hABCD);
      checkOutput("dw_land_ack", dbg_ack, 0);
      model[9] = 32'hABCD;
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd4);
      checkOutput("dw_ack", dbg_ack, 1);
      checkOutput("dw_ack_we", rf_we, 0);
      checkOutput("dw_r9", id_data1, 32'hABCD);
      checkOutput("dw_r4", id_data2, 32'h102);
      dbg_req = 1'b0;
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("dw_ack_drop", dbg_ack, 0);

      // Debug read of the stack pointer
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd29;
      #1;
      checkOutput("dr29_run_stall", stall, 0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("dr29_rd_stall", stall, 1);
      checkOutput("dr29_rd_raddr1", rf_raddr1, 29);
      checkOutput("dr29_rd_ack", dbg_ack, 0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("dr29_ack", dbg_ack, 1);
      checkOutput("dr29_ack_stall", stall, 0);
      checkOutput("dr29_rdata", dbg_rdata, 252);
      dbg_req = 1'b0;
      tick();
      checkOutput("dr29_ack_drop", dbg_ack, 0);
      checkOutput("dr29_rdata_hold", dbg_rdata, 252);

      // Debug read of r10 while WB writes r10 in the read cycle
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      tick();
      applyStimulus(1'b1, 5'd10, 32'h55, 5'd0, 5'd10);
      checkOutput("dr10_rd_stall", stall, 1);
      checkOutput("dr10_rd_we", rf_we, 1);
      checkOutput("dr10_rd_id2", id_data2, 32'h55);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("dr10_ack", dbg_ack, 1);
      checkOutput("dr10_rdata", dbg_rdata, 32'h55);
      dbg_req = 1'b0;
      tick();

      // Randomized WB traffic with ID reads
      for (int n = 0; n < 300; n++) begin
         rWe = 1'($urandom_range(0, 1));
         rWa = 5'($urandom_range(0, 31));
         rWd = $urandom;
         rRs = 5'($urandom_range(0, 31));
         rRt = (n % 4 == 0) ? rWa : 5'($urandom_range(0, 31));
         applyStimulus(rWe, rWa, rWd, rRs, rRt);
         checkOutput($sformatf("rnd%0d_we", n), rf_we, rWe && (rWa != 5'd0));
         checkOutput($sformatf("rnd%0d_id1", n), id_data1, predict(rRs));
         checkOutput($sformatf("rnd%0d_id2", n), id_data2, predict(rRt));
         tick();
      end
      readAll("final");

      // Reset in mid-sweep with a pending debug read
      reset = 1'b1;
      #1;
      checkOutput("rst2_stall", stall, 1);
      checkOutput("rst2_rdata", dbg_rdata, 0);
      checkOutput("rst2_waddr", rf_waddr, 0);
      @(negedge Clk);
      reset = 1'b0;
      sweepCheck(12);
      reset = 1'b1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd29;
      #1;
      checkOutput("rst3_waddr", rf_waddr, 0);
      checkOutput("rst3_ack", dbg_ack, 0);
      @(negedge Clk);
      reset = 1'b0;
      sweepCheck(32);
      resetModel();
      gotAck = 1'b0;
      for (int k = 0; k < 4 && !gotAck; k++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
         if (dbg_ack) gotAck = 1'b1;
         else tick();
      end
      checkOutput("rst3_ack_seen", 32'(gotAck), 1);
      checkOutput("rst3_rdata", dbg_rdata, 252);
      dbg_req = 1'b0;
      tick();
      readAll("resweep");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
